// File: rtl/sha256_host_pkg.sv
// Shared types and constants for the sha256 host-side controller.
package sha256_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DISCARD,
    S_START,
    S_WAIT,
    S_RD_ADDR,
    S_RD_WAIT,
    S_RD_OUT
  } state_t;

  localparam int DIGEST_WORDS   = 8;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/sha256_host_rdpipe.sv
// Read-latency tracker: a launch pulse emerges as capture exactly RD_LAT cycles
// later, marking the cycle in which mem_read_data holds the requested word.
module sha256_host_rdpipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic launch,
  output logic capture
);

  logic [RD_LAT-1:0] vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
    end else begin
      vld[0] <= launch;
      for (int i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];
    end
  end

  assign capture = vld[RD_LAT-1];

endmodule

// File: rtl/sha256_host_ctrl.sv
// Host controller for the sha256 engine: loads the message into shared memory,
// runs the start/done handshake, then streams the digest back out.
// Optional engine watchdog is compiled in with `define SHA_HOST_TIMEOUT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | no job; host owns memory; waits for in_valid
// LOAD      | accepting message words, writing to msg_addr+wcnt
// DISCARD   | overflowed; dropping words until in_last
// START     | one-cycle eng_start pulse; engine takes memory
// WAIT      | engine running; waits for rising eng_done
// RD_ADDR   | presents out_addr+rcnt to memory
// RD_WAIT   | waits RD_LAT cycles for read data
// RD_OUT    | offers digest word until dig_ready
module sha256_host_ctrl
  import sha256_host_pkg::*;
#(
  parameter int MAX_WORDS      = 512,
  parameter int RD_LAT         = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] msg_addr,
  input  logic [15:0] out_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [1:0]  in_bytes,
  output logic        mem_sel,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        eng_start,
  output logic [31:0] eng_size,
  output logic [31:0] eng_message_addr,
  output logic [31:0] eng_output_addr,
  input  logic        eng_done,
  output logic        dig_valid,
  input  logic        dig_ready,
  output logic [31:0] dig_data,
  output logic        dig_last,
  output logic        busy,
  output logic        err
);

  localparam int WCNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WORDS);
  localparam logic [2:0] RCNT_LAST = 3'(DIGEST_WORDS - 1);

  state_t            state, state_nxt;
  logic [15:0]       msg_base, out_base;
  logic [WCNT_W-1:0] wcnt;
  logic [2:0]        rcnt;
  logic [31:0]       size_q, dig_q;
  logic              done_q, done_rise, overflow, capture, timeout;
  logic [2:0]        last_bytes;

  assign done_rise  = eng_done & ~done_q;
  assign overflow   = (wcnt == WCNT_MAX);
  assign last_bytes = (in_bytes == 2'd0) ? 3'(BYTES_PER_WORD) : {1'b0, in_bytes};

  sha256_host_rdpipe #(.RD_LAT(RD_LAT)) u_rdpipe (
    .clk     (clk),
    .reset_n (reset_n),
    .launch  (state == S_RD_ADDR),
    .capture (capture)
  );

`ifdef SHA_HOST_TIMEOUT_EN
  logic [31:0] tcnt;

  // Down-counter loaded on START; terminal count in WAIT is the watchdog expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            tcnt <= '0;
    else if (state == S_START)               tcnt <= 32'(TIMEOUT_CYCLES - 1);
    else if (state == S_WAIT && tcnt != '0)  tcnt <= tcnt - 1'b1;
  end

  assign timeout = (state == S_WAIT) && (tcnt == '0);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      msg_base <= '0;
      out_base <= '0;
      wcnt     <= '0;
      rcnt     <= '0;
      size_q   <= '0;
      dig_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= eng_done;
      case (state)
        S_IDLE: if (in_valid) begin
          msg_base <= msg_addr;
          out_base <= out_addr;
          wcnt     <= '0;
          rcnt     <= '0;
        end
        S_LOAD: if (in_valid && !overflow) begin
          wcnt <= wcnt + 1'b1;
          if (in_last) size_q <= (32'(wcnt) << 2) + 32'(last_bytes);
        end
        S_RD_WAIT: if (capture) dig_q <= mem_read_data;
        S_RD_OUT:  if (dig_ready) rcnt <= rcnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt      = state;
    in_ready       = 1'b0;
    mem_sel        = 1'b1;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    eng_start      = 1'b0;
    dig_valid      = 1'b0;
    dig_last       = 1'b0;
    err            = 1'b0;
    case (state)
      S_IDLE: if (in_valid) state_nxt = S_LOAD;
      S_LOAD: begin
        in_ready = 1'b1;
        mem_addr = msg_base + 16'(wcnt);
        if (in_valid) begin
          if (overflow) begin
            err       = 1'b1;
            state_nxt = in_last ? S_IDLE : S_DISCARD;
          end else begin
            mem_we         = 1'b1;
            mem_write_data = in_data;
            if (in_last) state_nxt = S_START;
          end
        end
      end
      S_DISCARD: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = S_IDLE;
      end
      S_START: begin
        eng_start = 1'b1;
        mem_sel   = 1'b0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        mem_sel = 1'b0;
        if (done_rise) begin
          state_nxt = S_RD_ADDR;
        end else if (timeout) begin
          err       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        mem_addr  = out_base + 16'(rcnt);
        state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        mem_addr = out_base + 16'(rcnt);
        if (capture) state_nxt = S_RD_OUT;
      end
      S_RD_OUT: begin
        mem_addr  = out_base + 16'(rcnt);
        dig_valid = 1'b1;
        dig_last  = (rcnt == RCNT_LAST);
        if (dig_ready) state_nxt = dig_last ? S_IDLE : S_RD_ADDR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign eng_size         = size_q;
  assign eng_message_addr = {16'h0000, msg_base};
  assign eng_output_addr  = {16'h0000, out_base};
  assign dig_data         = dig_q;
  assign busy             = (state != S_IDLE);

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Randomized bench for sha256_host_ctrl with a memory model, a behavioural
// engine model and per-job expectations derived from the message contents.
module tb_sha256_host_ctrl;

  localparam int MAXW = 20;
  localparam int RDL  = 3;
  localparam int TOC  = 100;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic [15:0] msg_addr = '0, out_addr = '0;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_bytes = '0;
  logic        mem_sel, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic        eng_start, eng_done;
  logic [31:0] eng_size, eng_message_addr, eng_output_addr;
  logic        dig_valid, dig_ready = 1'b0, dig_last, busy, err;
  logic [31:0] dig_data;

  always #5 clk = ~clk;

  sha256_host_ctrl #(.MAX_WORDS(MAXW), .RD_LAT(RDL), .TIMEOUT_CYCLES(TOC)) dut (
    .clk(clk), .reset_n(reset_n), .msg_addr(msg_addr), .out_addr(out_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .in_bytes(in_bytes), .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .eng_start(eng_start), .eng_size(eng_size), .eng_message_addr(eng_message_addr),
    .eng_output_addr(eng_output_addr), .eng_done(eng_done), .dig_valid(dig_valid),
    .dig_ready(dig_ready), .dig_data(dig_data), .dig_last(dig_last), .busy(busy), .err(err)
  );

  // Shared memory: host port when mem_sel=1, engine port otherwise; 3-cycle read.
  logic [31:0] mem [0:65535];
  logic [31:0] rp0, rp1, rp2;
  logic        eng_we = 1'b0;
  logic [15:0] eng_wa = '0;
  logic [31:0] eng_wd = '0;

  always @(posedge clk) begin
    if (mem_sel && mem_we)      mem[mem_addr] <= mem_write_data;
    else if (!mem_sel && eng_we) mem[eng_wa]  <= eng_wd;
    rp0 <= mem[mem_addr];
    rp1 <= rp0;
    rp2 <= rp1;
  end
  assign mem_read_data = rp2;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Monitors
  int          cyc = 0;
  logic [47:0] wq[$];
  logic [31:0] bq[$];
  logic        lq[$];
  int          n_start = 0, n_err = 0, start_cyc = 0, err_cyc = 0;
  logic [31:0] size_seen = '0, msga_seen = '0;
  logic        early = 1'b0, sel_bad = 1'b0, eng_running = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_sel && mem_we) wq.push_back({mem_addr, mem_write_data});
    if (mem_we && !mem_sel) sel_bad = 1'b1;
    if (eng_running && mem_sel) sel_bad = 1'b1;
    if (eng_start) begin
      n_start++;
      size_seen = eng_size;
      msga_seen = eng_message_addr;
      start_cyc = cyc;
    end
    if (err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (dig_valid && eng_running) early = 1'b1;
    if (dig_valid && dig_ready) begin
      bq.push_back(dig_data);
      lq.push_back(dig_last);
    end
  end

  // Engine model: drops done after start, later writes the digest and raises done.
  logic [31:0] exp_dig [8];
  int          eng_delay = 4;
  logic        eng_abort = 1'b0;

  initial begin
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_start) begin
        logic [15:0] oa;
        oa = eng_output_addr[15:0];
        eng_running = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        for (int k = 0; k < eng_delay && !eng_abort; k++) @(negedge clk);
        if (!eng_abort) begin
          for (int i = 0; i < 8; i++) begin
            eng_we = 1'b1;
            eng_wa = oa + 16'(i);
            eng_wd = exp_dig[i];
            @(negedge clk);
          end
          eng_we   = 1'b0;
          eng_done = 1'b1;
        end
        eng_running = 1'b0;
      end
    end
  end

  localparam logic [31:0] ABC_DIG [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                          32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  task automatic clear_logs();
    wq.delete(); bq.delete(); lq.delete();
    n_start = 0; n_err = 0; early = 1'b0; sel_bad = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] b);
    bit ok = 0;
    int guard = 0;
    in_valid = 1'b1; in_data = d; in_last = last; in_bytes = b;
    while (!ok && guard < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) chk("in_handshake_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cnt = 0;
    do begin @(negedge clk); cnt++; end while (busy && cnt < 400);
    chk(tag, busy, 0);
  endtask

  task automatic run_job(input int n, input logic [1:0] lb, input logic [15:0] ma,
                         input logic [15:0] oa, input bit gaps, input int stall_beat, input bit abc);
    logic [31:0] words[$];
    bit ovf;
    int nw, cnt, exp_size;
    clear_logs();
    for (int i = 0; i < 8; i++) exp_dig[i] = abc ? ABC_DIG[i] : $urandom;
    eng_delay = $urandom_range(2, 12);
    msg_addr = ma; out_addr = oa;
    ovf = (n > MAXW);
    nw  = ovf ? MAXW : n;
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      d = abc ? 32'h61626300 : $urandom;
      words.push_back(d);
      send_word(d, i == n - 1, (i == n - 1) ? lb : 2'($urandom));
    end
    if (!ovf) begin
      for (int b = 0; b < 8; b++) begin
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!dig_valid && cnt < 300);
        if (!dig_valid) begin
          chk("digest_timeout", 0, 1);
          break;
        end
        if (b > 0) chk("read_spacing", cnt, RDL + 2);
        if (b == stall_beat) begin
          logic [31:0] d0;
          logic [15:0] a0;
          bit moved = 0;
          d0 = dig_data; a0 = mem_addr;
          repeat (10) begin
            @(negedge clk);
            if (dig_data !== d0 || mem_addr !== a0 || !dig_valid) moved = 1;
          end
          chk("stall_hold", moved, 0);
        end
        dig_ready = 1'b1;
        @(posedge clk);
        #1;
        dig_ready = 1'b0;
      end
    end
    wait_idle("busy_end");
    exp_size = 4 * (n - 1) + ((lb == 2'd0) ? 4 : int'(lb));
    chk("write_count", wq.size(), nw);
    for (int i = 0; i < nw && i < wq.size(); i++) begin
      logic [15:0] ea;
      ea = ma + 16'(i);
      chk("write_addr", wq[i][47:32], ea);
      chk("write_data", wq[i][31:0], words[i]);
    end
    chk("start_count", n_start, ovf ? 0 : 1);
    chk("err_count", n_err, ovf ? 1 : 0);
    chk("mem_ownership", sel_bad, 0);
    if (!ovf) begin
      chk("eng_size", size_seen, exp_size);
      chk("eng_msg_addr", msga_seen, {16'h0000, ma});
      chk("early_read", early, 0);
      chk("beat_count", bq.size(), 8);
      for (int i = 0; i < 8 && i < bq.size(); i++) begin
        chk("digest_word", bq[i], exp_dig[i]);
        chk("digest_last", lq[i], i == 7);
      end
    end
  endtask

  initial begin
    #1;
    chk("rst_mem_sel", mem_sel, 1);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_dig_valid", dig_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_dig_data", dig_data, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_job(1, 2'd3, 16'h0010, 16'h0100, 0, -1, 1);
    run_job(16, 2'd0, 16'($urandom), 16'($urandom), 1, -1, 0);
    run_job(MAXW + 2, 2'd2, 16'($urandom), 16'($urandom), 1, -1, 0);
    run_job(MAXW + 1, 2'd1, 16'($urandom), 16'($urandom), 0, -1, 0);
    run_job(MAXW, 2'd0, 16'($urandom), 16'($urandom), 1, -1, 0);
    // eng_done is still high from the previous job across this start
    run_job(5, 2'd1, 16'($urandom), 16'($urandom), 0, 2, 0);
    run_job(12, 2'd2, 16'hfffa, 16'hfffc, 1, -1, 0);
    for (int j = 0; j < 4; j++)
      run_job($urandom_range(1, MAXW), 2'($urandom), 16'($urandom), 16'($urandom),
              1, $urandom_range(0, 9) - 1, 0);

    // Reset asserted while the engine is running
    clear_logs();
    eng_delay = 60;
    msg_addr = 16'h0200; out_addr = 16'h0300;
    send_word($urandom, 1'b1, 2'd0);
    begin
      int cnt = 0;
      while (n_start == 0 && cnt < 50) begin @(negedge clk); cnt++; end
      chk("rst_job_started", n_start, 1);
    end
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_mem_sel", mem_sel, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_size", eng_size, 0);
    chk("midrst_msg_addr", eng_message_addr, 0);
    chk("midrst_dig_valid", dig_valid, 0);
    eng_abort = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    eng_abort = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_digest", bq.size(), 0);
    chk("midrst_idle", busy, 0);
    run_job(3, 2'd0, 16'($urandom), 16'($urandom), 1, -1, 0);

`ifdef SHA_HOST_TIMEOUT_EN
    clear_logs();
    eng_delay = 3 * TOC;
    send_word($urandom, 1'b1, 2'd1);
    begin
      int cnt = 0;
      while (n_err == 0 && cnt < 3 * TOC) begin @(negedge clk); cnt++; end
    end
    chk("timeout_err", n_err, 1);
    chk("timeout_cycle", err_cyc - start_cyc, TOC);
    wait_idle("timeout_idle");
    chk("timeout_mem_sel", mem_sel, 1);
    eng_abort = 1'b1;
    repeat (3) @(negedge clk);
    eng_abort = 1'b0;
    chk("timeout_no_digest", bq.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
